// File: rtl/wb_port_arbiter_pkg.sv
// Shared writeback types: request payload, arbiter state encoding and helpers.
// Reused by the long-latency unit, the WB stage and the write-port arbiter.
package wb_port_arbiter_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned XLEN   = 32;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  typedef enum logic {
    NORMAL = 1'b0,
    DRAIN  = 1'b1
  } wb_arb_state_t;

  // x0 is hardwired, so a request targeting it never reaches the register file
  function automatic logic is_rf_write(input logic valid, input logic [REG_AW-1:0] rd);
    return valid && (rd != '0);
  endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bundle of the pipeline/long-latency request ports and the register file write port.
interface wb_port_arbiter_if #(
  parameter int unsigned DEPTH = 4
) ();
  import wb_port_arbiter_pkg::*;

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic              pipe_valid;
  logic [REG_AW-1:0] pipe_rd;
  logic [XLEN-1:0]   pipe_data;
  logic              pipe_ready;
  logic              lu_valid;
  logic [REG_AW-1:0] lu_rd;
  logic [XLEN-1:0]   lu_data;
  logic              lu_ready;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [XLEN-1:0]   rf_wdata;
  logic [CW-1:0]     fifo_count;
  logic              draining;

  modport master (
    output pipe_valid, pipe_rd, pipe_data, lu_valid, lu_rd, lu_data,
    input  pipe_ready, lu_ready, rf_we, rf_waddr, rf_wdata, fifo_count, draining
  );

  modport slave (
    input  pipe_valid, pipe_rd, pipe_data, lu_valid, lu_rd, lu_data,
    output pipe_ready, lu_ready, rf_we, rf_waddr, rf_wdata, fifo_count, draining
  );

endinterface

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback requests; pointers wrap modulo DEPTH.
module wb_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  wb_req_t                    push_data,
  input  logic                       pop,
  output wb_req_t                    head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  wb_req_t       mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO only lands when the head leaves the same cycle
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writes win, long-latency results are
// queued and drained in idle slots, and a full queue forces a drain phase.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  wb_port_arbiter_if.slave   bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  wb_arb_state_t     state;
  wb_req_t           fifo_head;
  wb_req_t           lu_req;
  wb_req_t           wr_req;
  logic [CW-1:0]     fifo_count;
  logic [CW-1:0]     next_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic              pipe_wr;
  logic              sel_pipe;
  logic              wr_sel;
  logic              pipe_ready_c;
  logic              lu_ready_c;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [XLEN-1:0]   rf_wdata;

  assign lu_req = '{rd: bus.lu_rd, data: bus.lu_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (lu_req),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Source selection and handshakes; lu_ready deliberately ignores lu_valid
  always_comb begin
    pipe_ready_c = 1'b0;
    fifo_pop     = 1'b0;
    sel_pipe     = 1'b0;
    pipe_wr      = is_rf_write(bus.pipe_valid, bus.pipe_rd);
    if (state == NORMAL) begin
      pipe_ready_c = 1'b1;
      sel_pipe     = pipe_wr;
      fifo_pop     = !fifo_empty && !pipe_wr;
    end else begin
      fifo_pop     = !fifo_empty;
    end
    lu_ready_c = !fifo_full || fifo_pop;
    fifo_push  = lu_ready_c && is_rf_write(bus.lu_valid, bus.lu_rd);
    wr_sel     = sel_pipe || fifo_pop;
    wr_req     = sel_pipe ? wb_req_t'{rd: bus.pipe_rd, data: bus.pipe_data} : fifo_head;
    next_count = fifo_count + CW'(fifo_push) - CW'(fifo_pop);
  end

  // Drain mode with hysteresis, plus the registered write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= NORMAL;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      case (state)
        NORMAL: if (next_count == CW'(DEPTH))      state <= DRAIN;
        DRAIN:  if (next_count <= CW'(DEPTH / 2))  state <= NORMAL;
        default:                                   state <= NORMAL;
      endcase
      rf_we <= wr_sel;
      if (wr_sel) begin
        rf_waddr <= wr_req.rd;
        rf_wdata <= wr_req.data;
      end
    end
  end

  assign bus.pipe_ready = pipe_ready_c;
  assign bus.lu_ready   = lu_ready_c;
  assign bus.rf_we      = rf_we;
  assign bus.rf_waddr   = rf_waddr;
  assign bus.rf_wdata   = rf_wdata;
  assign bus.fifo_count = fifo_count;
  assign bus.draining   = (state == DRAIN);

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: expected rf writes are queued with their
// due cycle and a negedge monitor checks every write the DUT makes.
module tb_wb_port_arbiter;
  import wb_port_arbiter_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst;

  wb_port_arbiter_if #(.DEPTH(DEPTH)) bus ();

  wb_port_arbiter #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          at;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_now    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // One stimulus cycle; readies are checked shortly after the inputs settle
  task automatic drive(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                       input logic exp_pr, input logic exp_lr);
    @(negedge clk);
    bus.pipe_valid = pv;
    bus.pipe_rd    = prd;
    bus.pipe_data  = pd;
    bus.lu_valid   = lv;
    bus.lu_rd      = lrd;
    bus.lu_data    = ld;
    n_now          = cyc;
    #1;
    check("pipe_ready", 32'(bus.pipe_ready), 32'(exp_pr));
    check("lu_ready", 32'(bus.lu_ready), 32'(exp_lr));
  endtask

  task automatic idle(input logic exp_pr, input logic exp_lr);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, exp_pr, exp_lr);
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d, input int off);
    sb.push_back('{rd: rd, data: d, at: n_now + off});
  endtask

  task automatic check_status(input int exp_count, input logic exp_drain);
    check("fifo_count", 32'(bus.fifo_count), 32'(exp_count));
    check("draining", 32'(bus.draining), 32'(exp_drain));
  endtask

  // Monitor: every rf write must match the queue head on its due cycle
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.rf_we === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rf_unexpected at cycle %0d: write x%0d=0x%0h, expected no write",
                   cyc, bus.rf_waddr, bus.rf_wdata);
        end else begin
          e = sb.pop_front();
          check("rf_waddr", 32'(bus.rf_waddr), 32'(e.rd));
          check("rf_wdata", bus.rf_wdata, e.data);
          check("rf_cycle", 32'(cyc), 32'(e.at));
        end
      end else if (sb.size() != 0 && sb[0].at <= cyc) begin
        e = sb.pop_front();
        n_checks++;
        n_fail++;
        $display("FAIL rf_missing at cycle %0d: got no write, expected x%0d=0x%0h",
                 cyc, e.rd, e.data);
      end
    end
  end

  initial begin
    rst            = 1'b1;
    bus.pipe_valid = 1'b0;
    bus.pipe_rd    = '0;
    bus.pipe_data  = '0;
    bus.lu_valid   = 1'b0;
    bus.lu_rd      = '0;
    bus.lu_data    = '0;

    repeat (2) @(negedge clk);
    #1;
    check("reset_rf_we", 32'(bus.rf_we), 32'd0);
    check("reset_rf_waddr", 32'(bus.rf_waddr), 32'd0);
    check("reset_rf_wdata", bus.rf_wdata, 32'd0);
    check_status(0, 1'b0);
    check("reset_pipe_ready", 32'(bus.pipe_ready), 32'd1);
    check("reset_lu_ready", 32'(bus.lu_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Pipe-only write lands exactly one cycle later
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1);
    expect_wr(5'd5, 32'hDEADBEEF, 1);
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b1);

    // Long-latency result drains in the next idle slot (two cycles after accept)
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h12, 1'b1, 1'b1);
    expect_wr(5'd7, 32'h12, 2);
    idle(1'b1, 1'b1);
    check_status(1, 1'b0);
    idle(1'b1, 1'b1);
    check_status(0, 1'b0);

    // A pipe write in the would-be slot pushes the queued result one cycle later
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h12, 1'b1, 1'b1);
    drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1);
    expect_wr(5'd3, 32'h33, 1);
    expect_wr(5'd7, 32'h12, 2);
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b1);

    // Fill under continuous pipe writes, then drain with hysteresis
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 5'(10 + k), 32'hA000 + 32'(k), 1'b1, 5'(20 + k), 32'hB000 + 32'(k), 1'b1, 1'b1);
      expect_wr(5'(10 + k), 32'hA000 + 32'(k), 1);
    end
    drive(1'b1, 5'd14, 32'hA004, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    check_status(4, 1'b1);
    expect_wr(5'd20, 32'hB000, 1);
    drive(1'b1, 5'd14, 32'hA004, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    check_status(3, 1'b1);
    expect_wr(5'd21, 32'hB001, 1);
    drive(1'b1, 5'd14, 32'hA004, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1);
    check_status(2, 1'b0);
    expect_wr(5'd14, 32'hA004, 1);
    idle(1'b1, 1'b1);
    expect_wr(5'd22, 32'hB002, 1);
    idle(1'b1, 1'b1);
    expect_wr(5'd23, 32'hB003, 1);
    idle(1'b1, 1'b1);
    check_status(0, 1'b0);

    // x0 handling on both sources
    drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd9, 32'h99, 1'b1, 1'b1);
    expect_wr(5'd4, 32'h44, 1);
    drive(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1);
    check_status(1, 1'b0);
    expect_wr(5'd9, 32'h99, 1);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h1234, 1'b1, 1'b1);
    check_status(0, 1'b0);
    idle(1'b1, 1'b1);
    check_status(0, 1'b0);
    idle(1'b1, 1'b1);

    // Full FIFO in DRAIN accepts a push alongside the pop
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 5'(1 + k), 32'hD000 + 32'(k), 1'b1, 5'(24 + k), 32'hE000 + 32'(k), 1'b1, 1'b1);
      expect_wr(5'(1 + k), 32'hD000 + 32'(k), 1);
    end
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd28, 32'hE004, 1'b0, 1'b1);
    check_status(4, 1'b1);
    expect_wr(5'd24, 32'hE000, 1);
    idle(1'b0, 1'b1);
    check_status(4, 1'b1);
    expect_wr(5'd25, 32'hE001, 1);
    idle(1'b0, 1'b1);
    check_status(3, 1'b1);
    expect_wr(5'd26, 32'hE002, 1);
    idle(1'b1, 1'b1);
    check_status(2, 1'b0);
    expect_wr(5'd27, 32'hE003, 1);
    idle(1'b1, 1'b1);
    check_status(1, 1'b0);
    expect_wr(5'd28, 32'hE004, 1);
    idle(1'b1, 1'b1);
    check_status(0, 1'b0);

    // Asynchronous reset with three results queued drops them all
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'(1 + k), 32'hF000 + 32'(k), 1'b1, 5'(29 + k), 32'hF100 + 32'(k), 1'b1, 1'b1);
      expect_wr(5'(1 + k), 32'hF000 + 32'(k), 1);
    end
    idle(1'b1, 1'b1);
    check_status(3, 1'b0);
    #1;
    rst = 1'b1;
    sb.delete();
    #1;
    check("midrst_rf_we", 32'(bus.rf_we), 32'd0);
    check_status(0, 1'b0);
    check("midrst_pipe_ready", 32'(bus.pipe_ready), 32'd1);
    check("midrst_lu_ready", 32'(bus.lu_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) idle(1'b1, 1'b1);
    check_status(0, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
